// File: rtl/if_id_fetch_buf.sv
// IF/ID decoupling buffer: pairs each instruction-SRAM response with its PC and
// queues the pair in a small FIFO so a decode stall never drops a fetched instruction.
module if_id_fetch_buf #(
  parameter int DEPTH  = 2,
  parameter int PC_W   = 64,
  parameter int INST_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [5:0]        stall,
  input  logic              flush,
  input  logic              fetch_en,
  input  logic [PC_W-1:0]   fetch_pc,
  input  logic [INST_W-1:0] inst_sram_rdata,
  output logic              id_valid,
  output logic [PC_W-1:0]   id_pc,
  output logic [INST_W-1:0] id_inst,
  output logic              id_misalign,
  output logic              stallreq_if
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
    logic              misalign;
  } entry_t;

  entry_t             mem [DEPTH];
  entry_t             head;
  logic               pend_valid;
  logic [PC_W-1:0]    pend_pc;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [CNT_W:0]     occupancy;
  logic               has_data;
  logic               push;
  logic               pop;
  logic               unused_stall;

  // Only the ID hold bit matters here; the rest of the vector belongs to other stages.
  assign unused_stall = ^{stall[5:2], stall[0]};

  assign has_data = (count != '0);
  assign push     = pend_valid & ~flush;
  assign pop      = id_valid & ~stall[1] & ~flush;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid <= 1'b0;
      count      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
    end else begin
      pend_valid <= fetch_en & ~flush;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      // A redirect empties the queue by collapsing the read side onto the write side.
      if (flush) begin
        count  <= '0;
        rd_ptr <= wr_ptr;
      end else begin
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  // NOTE: the entry storage and pending PC carry no reset; count/pend_valid
  // gate every read, so their contents are never observed until written.
  always_ff @(posedge clk) begin
    if (fetch_en) pend_pc <= fetch_pc;
    if (push) mem[wr_ptr] <= '{pc:       pend_pc,
                              inst:     inst_sram_rdata,
                              misalign: (pend_pc[1:0] != 2'b00)};
  end

  assign head        = mem[rd_ptr];
  assign id_valid    = has_data & ~flush;
  assign id_pc       = has_data ? head.pc       : '0;
  assign id_inst     = has_data ? head.inst     : '0;
  assign id_misalign = has_data ? head.misalign : 1'b0;

  // Count the in-flight response as occupied so it always has a slot to land in.
  assign occupancy   = {1'b0, count} + {{CNT_W{1'b0}}, pend_valid};
  assign stallreq_if = (occupancy >= (CNT_W + 1)'(DEPTH));

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && (count == CNT_W'(DEPTH))))
    else $error("if_id_fetch_buf: push into full FIFO");

endmodule

// File: tb/tb_if_id_fetch_buf.sv
// Self-checking bench for if_id_fetch_buf: vector table for the stream/stall/flush
// timelines, scoreboard for every pc/inst pair, hand sequences for wrap, misalign, reset.
module tb_if_id_fetch_buf;
  localparam int PC_W   = 64;
  localparam int INST_W = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [5:0]        stall;
  logic              flush;
  logic              fetch_en;
  logic [PC_W-1:0]   fetch_pc;
  logic [INST_W-1:0] inst_sram_rdata;
  logic              id_valid;
  logic [PC_W-1:0]   id_pc;
  logic [INST_W-1:0] id_inst;
  logic              id_misalign;
  logic              stallreq_if;

  if_id_fetch_buf #(.DEPTH(2), .PC_W(PC_W), .INST_W(INST_W)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .fetch_en(fetch_en), .fetch_pc(fetch_pc), .inst_sram_rdata(inst_sram_rdata),
    .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst),
    .id_misalign(id_misalign), .stallreq_if(stallreq_if)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
    logic              mis;
  } exp_t;

  typedef struct {
    logic            fe;
    logic [PC_W-1:0] pc;
    logic            st1;
    logic            fl;
    logic            v;
    logic [PC_W-1:0] epc;
    logic            sr;
  } vec_t;

  exp_t            sb_q[$];
  vec_t            vecs[$];
  int              chk_cnt  = 0;
  int              pass_cnt = 0;
  logic            prev_fe  = 1'b0;
  logic [PC_W-1:0] prev_pc  = '0;

  function automatic logic [INST_W-1:0] inst_of(input logic [PC_W-1:0] pc);
    return {pc[15:0], pc[31:16]} ^ 32'h0000_0013;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // One clock cycle: drive at negedge, sample 1ns later, then advance the scoreboard.
  // With obey=1 the fetcher drops its request while stallreq_if is high.
  task automatic cycle(input logic fe, input logic [PC_W-1:0] pc,
                       input logic st1, input logic fl, input logic obey);
    logic fe_eff;
    exp_t e;
    @(negedge clk);
    fe_eff          = fe & ~(obey & stallreq_if);
    fetch_en        = fe_eff;
    fetch_pc        = pc;
    stall           = {4'b0000, st1, 1'b0};
    flush           = fl;
    inst_sram_rdata = prev_fe ? inst_of(prev_pc) : 32'hDEAD_BEEF;
    #1;
    if (id_valid) begin
      if (sb_q.size() == 0) begin
        chk_cnt++;
        $display("FAIL sb_spurious: id_valid=1 with pc 0x%0h, expected no entry", id_pc);
      end else begin
        check("sb_pc", id_pc, sb_q[0].pc);
        check("sb_inst", id_inst, sb_q[0].inst);
        check("sb_misalign", id_misalign, sb_q[0].mis);
      end
    end
    if (fl) sb_q.delete();
    else begin
      if (id_valid && !st1 && sb_q.size() > 0) void'(sb_q.pop_front());
      if (fe_eff) begin
        e.pc   = pc;
        e.inst = inst_of(pc);
        e.mis  = (pc[1:0] != 2'b00);
        sb_q.push_back(e);
      end
    end
    prev_fe = fe_eff;
    prev_pc = pc;
  endtask

  task automatic add(input logic fe, input logic [PC_W-1:0] pc, input logic st1, input logic fl,
                     input logic v, input logic [PC_W-1:0] epc, input logic sr);
    vec_t t;
    t.fe = fe; t.pc = pc; t.st1 = st1; t.fl = fl; t.v = v; t.epc = epc; t.sr = sr;
    vecs.push_back(t);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [PC_W-1:0] a, b, c, p, rpc;
    logic st1, fl, fe;

    a = 64'h8000_0000; b = 64'h8000_0040; c = 64'h8000_0080;
    // Stream of three fetches, no stalls
    add(1, a,     0, 0, 0, 0,     0);
    add(1, a + 4, 0, 0, 0, 0,     0);
    add(1, a + 8, 0, 0, 1, a,     1);
    add(0, 0,     0, 0, 1, a + 4, 1);
    add(0, 0,     0, 0, 1, a + 8, 0);
    add(0, 0,     0, 0, 0, 0,     0);
    // Decode stall for three cycles: head frozen, FIFO fills, fetch held
    add(1, b,     0, 0, 0, 0,     0);
    add(1, b + 4, 0, 0, 0, 0,     0);
    add(0, 0,     1, 0, 1, b,     1);
    add(0, 0,     1, 0, 1, b,     1);
    add(0, 0,     1, 0, 1, b,     1);
    add(0, 0,     0, 0, 1, b,     1);
    add(1, b + 8, 0, 0, 1, b + 4, 0);
    add(0, 0,     0, 0, 0, 0,     0);
    add(0, 0,     0, 0, 1, b + 8, 0);
    add(0, 0,     0, 0, 0, 0,     0);
    // Flush with two buffered entries plus a pending response, then new target
    add(1, c,     0, 0, 0, 0,     0);
    add(1, c + 4, 0, 0, 0, 0,     0);
    add(1, c + 8, 1, 0, 1, c,     1);
    add(1, 64'h8000_00C0, 1, 1, 0, c, 1);
    add(1, 64'h8000_0100, 0, 0, 0, 0, 0);
    add(0, 0,     0, 0, 0, 0,     0);
    add(0, 0,     0, 0, 1, 64'h8000_0100, 0);
    add(0, 0,     0, 0, 0, 0,     0);

    rst_n = 1'b0; stall = '0; flush = 0; fetch_en = 0; fetch_pc = '0; inst_sram_rdata = '0;
    #1;
    check("rst_id_valid", id_valid, 0);
    check("rst_id_pc", id_pc, 0);
    check("rst_id_inst", id_inst, 0);
    check("rst_id_misalign", id_misalign, 0);
    check("rst_stallreq", stallreq_if, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      cycle(vecs[i].fe, vecs[i].pc, vecs[i].st1, vecs[i].fl, 1'b0);
      check($sformatf("vec%0d_id_valid", i), id_valid, vecs[i].v);
      check($sformatf("vec%0d_id_pc", i), id_pc, vecs[i].epc);
      check($sformatf("vec%0d_stallreq", i), stallreq_if, vecs[i].sr);
    end

    // Ten back-to-back fetches: push and pop every cycle across pointer wraps
    for (int i = 0; i < 13; i++) begin
      cycle(i < 10, 64'h8000_0200 + 64'(4 * i), 0, 0, 1'b0);
      check($sformatf("wrap%0d_id_valid", i), id_valid, (i >= 2 && i <= 11));
    end

    // Misaligned PC flags only its own entry
    for (int i = 0; i < 6; i++) begin
      cycle(i < 3, 64'h8000_0300 + 64'(2 * i), 0, 0, 1'b0);
      check($sformatf("mis%0d_id_misalign", i), id_misalign, (i == 3));
    end

    // Asynchronous reset with two entries buffered
    p = 64'h8000_0400;
    cycle(1, p, 0, 0, 1'b0);
    cycle(1, p + 4, 0, 0, 1'b0);
    cycle(0, 0, 1, 0, 1'b0);
    cycle(0, 0, 1, 0, 1'b0);
    check("pre_rst_stallreq", stallreq_if, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_id_valid", id_valid, 0);
    check("arst_id_pc", id_pc, 0);
    check("arst_id_inst", id_inst, 0);
    check("arst_id_misalign", id_misalign, 0);
    check("arst_stallreq", stallreq_if, 0);
    sb_q.delete();
    prev_fe = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle(i == 2, 64'h8000_0500, 0, 0, 1'b0);
      check($sformatf("post_rst%0d_id_valid", i), id_valid, (i == 4));
    end

    // Randomised traffic with a fetcher that honours backpressure
    rpc = 64'h8000_1000;
    for (int i = 0; i < 300; i++) begin
      st1 = ($urandom_range(9) < 3);
      fl  = ($urandom_range(24) == 0);
      fe  = ($urandom_range(3) != 0);
      cycle(fe, rpc, st1, fl, 1'b1);
      if (fl) rpc = 64'h8000_2000 + 64'({$urandom_range(255), 2'b00});
      else rpc = rpc + (($urandom_range(15) == 0) ? 64'd2 : 64'd4);
    end
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0, 1'b0);
    check("drain_sb_empty", sb_q.size(), 0);
    check("drain_id_valid", id_valid, 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
